// File: rtl/prog_timer_if.sv
// Register-style control/status bundle for prog_timer.
// master drives prescale/load/mode/enable/irq_clear; slave returns toggled/expired/busy/irq.
interface prog_timer_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 24,
    parameter int PRE_W    = 8
);
    logic [PRE_W-1:0]    prescale;
    logic [WIDTH-1:0]    load_value;
    logic [CHANNELS-1:0] ch_load;
    logic [CHANNELS-1:0] ch_periodic;
    logic [CHANNELS-1:0] ch_enable;
    logic [CHANNELS-1:0] irq_clear;
    logic [CHANNELS-1:0] toggled;
    logic [CHANNELS-1:0] expired;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] irq_status;
    logic                irq;

    modport master (
        output prescale, load_value, ch_load, ch_periodic, ch_enable, irq_clear,
        input  toggled, expired, busy, irq_status, irq
    );

    modport slave (
        input  prescale, load_value, ch_load, ch_periodic, ch_enable, irq_clear,
        output toggled, expired, busy, irq_status, irq
    );
endinterface

// File: rtl/prog_timer.sv
// Multi-channel programmable timer: shared free-running prescaler, per-channel down-counters.
// Ports: clock, reset_n (async low), bus (prog_timer_if.slave). Optional IRQ flags: TIMER_IRQ_EN.
module prog_timer #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 24,
    parameter int PRE_W    = 8
) (
    input logic         clock,
    input logic         reset_n,
    prog_timer_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_e;

    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic                tick;
    state_e              state_q  [CHANNELS];
    logic [WIDTH-1:0]    cnt_q    [CHANNELS];
    logic [WIDTH-1:0]    reload_q [CHANNELS];
    logic [CHANNELS-1:0] toggled_q;
    logic [CHANNELS-1:0] expired_q;
    logic [CHANNELS-1:0] exp_evt;
    logic [CHANNELS-1:0] busy_d;

    // >= so that lowering prescale while running takes effect at once
    assign tick      = (pre_cnt_q >= bus.prescale);
    assign pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;

    // Expiry event; a load in the same cycle suppresses it
    always_comb begin
        exp_evt = '0;
        busy_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            busy_d[i]  = (state_q[i] == RUN);
            exp_evt[i] = (state_q[i] == RUN) && !bus.ch_load[i] && tick
                       && bus.ch_enable[i] && (cnt_q[i] == '0);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_q <= '0;
            toggled_q <= '0;
            expired_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= IDLE;
                cnt_q[i]    <= '0;
                reload_q[i] <= '0;
            end
        end else begin
            pre_cnt_q <= pre_cnt_d;
            expired_q <= exp_evt;
            for (int i = 0; i < CHANNELS; i++) begin
                unique case (state_q[i])
                    IDLE: begin
                        if (bus.ch_load[i]) begin
                            cnt_q[i]    <= bus.load_value;
                            reload_q[i] <= bus.load_value;
                            state_q[i]  <= RUN;
                        end
                    end
                    RUN: begin
                        if (bus.ch_load[i]) begin
                            cnt_q[i]    <= bus.load_value;
                            reload_q[i] <= bus.load_value;
                        end else if (tick && bus.ch_enable[i]) begin
                            if (cnt_q[i] != '0) begin
                                cnt_q[i] <= cnt_q[i] - 1'b1;
                            end else begin
                                toggled_q[i] <= ~toggled_q[i];
                                if (bus.ch_periodic[i]) begin
                                    cnt_q[i] <= reload_q[i];
                                end else begin
                                    state_q[i] <= IDLE;
                                end
                            end
                        end
                    end
                    default: state_q[i] <= IDLE;
                endcase
            end
        end
    end

    assign bus.toggled = toggled_q;
    assign bus.expired = expired_q;
    assign bus.busy    = busy_d;

`ifdef TIMER_IRQ_EN
    logic [CHANNELS-1:0] irq_status_q;

    // Set wins over a clear arriving in the same clock
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_status_q <= '0;
        end else begin
            irq_status_q <= (irq_status_q & ~bus.irq_clear) | exp_evt;
        end
    end

    assign bus.irq_status = irq_status_q;
    assign bus.irq        = |irq_status_q;
`else
    logic irq_clear_unused;

    assign irq_clear_unused = |bus.irq_clear;
    assign bus.irq_status   = '0;
    assign bus.irq          = 1'b0;
`endif
endmodule
